// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
// Holds the 16 opcode encodings, the bit positions of the instruction
// fields, the controller FSM state type and a small writeback helper.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 12;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_INC  = 4'b1000;
  localparam logic [3:0] OP_DEC  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_MOD  = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_CMP  = 4'b1110;
  localparam logic [3:0] OP_SWAP = 4'b1111;

  // Instruction word: [11:8] opcode, [7:6] rd, [5:4] ra, [3:2] rb,
  // [1] wb_en, [0] reserved.
  localparam int OPC_HI = 11;
  localparam int OPC_LO = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int RA_HI  = 5;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 2;
  localparam int WB_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Compare only produces flags; it never writes the register file.
  function automatic logic writes_back(input logic wb_en, input logic [3:0] opcode);
    return wb_en && (opcode != OP_CMP);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between the issue controller, its instruction/load source,
// the downstream combinational ALU and the result consumer.
//   instr_valid/instr/instr_ready : instruction channel
//   ld_valid/ld_addr/ld_data      : register-file load (no ready; only taken in IDLE)
//   alu_a/alu_b/alu_opcode        : operands presented to the ALU
//   alu_out/alu_flags             : combinational ALU answer
//   res_valid/res_ready/res_data/res_flags : result channel
// Handshake rule for both valid/ready channels: a transfer happens on a
// rising clk edge where valid and ready are both 1; the sender keeps its
// payload stable and valid high until that edge, and the receiver may
// change ready at any time without any transfer occurring.
interface alu_issue_ctrl_if #(parameter int NUM_REGS = 4);
  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              instr_valid;
  logic [11:0]       instr;
  logic              instr_ready;
  logic              ld_valid;
  logic [REG_AW-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [3:0]        alu_opcode;
  logic [7:0]        alu_out;
  logic [7:0]        alu_flags;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_data;
  logic [7:0]        res_flags;

  // Environment side: instruction/load source, ALU and result consumer.
  modport master (
    output instr_valid, instr, ld_valid, ld_addr, ld_data,
    output alu_out, alu_flags, res_ready,
    input  instr_ready, alu_a, alu_b, alu_opcode,
    input  res_valid, res_data, res_flags
  );

  // Controller side.
  modport slave (
    input  instr_valid, instr, ld_valid, ld_addr, ld_data,
    input  alu_out, alu_flags, res_ready,
    output instr_ready, alu_a, alu_b, alu_opcode,
    output res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x 8 register file: two asynchronous read ports and one
// synchronous write port. The choice between load and writeback data is
// made by the caller. Synchronous active-high reset clears every entry.
//   clk, rst           : clock, reset
//   we, waddr, wdata   : write port
//   raddr_a / rdata_a  : read port A
//   raddr_b / rdata_b  : read port B
module alu_regfile #(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [7:0]        rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [7:0]        rdata_b
);

  logic [7:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU.
// Accepts one instruction at a time, reads both operands from a small
// register file, holds them on the ALU for a settle cycle, captures the
// ALU result/flags, optionally writes the result back, and offers the
// result on a valid/ready channel. Loads into the register file are only
// taken while idle and win over a simultaneous instruction.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_issue_ctrl_if slave modport (all handshake/data signals)
//   state    : current FSM state, for observation
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 4
) (
  input  logic   clk,
  input  logic   rst,
  alu_issue_ctrl_if.slave bus,
  output state_t state
);

  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [REG_AW-1:0] rd_q;
  logic              wb_q;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [7:0]        rf_wdata;
  logic [7:0]        rdata_a;
  logic [7:0]        rdata_b;
  logic              unused_reserved;

  assign unused_reserved = bus.instr[0];

  // Ready is combinational so a load in the same cycle blocks acceptance.
  assign bus.instr_ready = !rst && (state == ST_IDLE) && !bus.ld_valid;

  // Load has priority; it is only possible in IDLE, writeback only in
  // CAPTURE, so the two never collide.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = bus.ld_addr;
    rf_wdata = bus.ld_data;
    if ((state == ST_IDLE) && bus.ld_valid) begin
      rf_we = 1'b1;
    end else if ((state == ST_CAPTURE) && writes_back(wb_q, bus.alu_opcode)) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = bus.alu_out;
    end
  end

  alu_regfile #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (REG_AW'(bus.instr[RA_HI:RA_LO])),
    .rdata_a (rdata_a),
    .raddr_b (REG_AW'(bus.instr[RB_HI:RB_LO])),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      rd_q           <= '0;
      wb_q           <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_opcode <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid && bus.instr_ready) begin
            // Operands are latched here, so a later writeback to ra/rb
            // cannot disturb the values already on the ALU.
            bus.alu_a      <= rdata_a;
            bus.alu_b      <= rdata_b;
            bus.alu_opcode <= bus.instr[OPC_HI:OPC_LO];
            rd_q           <= REG_AW'(bus.instr[RD_HI:RD_LO]);
            wb_q           <= bus.instr[WB_BIT];
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Settle cycle for the combinational ALU.
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          bus.res_data  <= bus.alu_out;
          bus.res_flags <= bus.alu_flags;
          bus.res_valid <= 1'b1;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, hand-written corner
// sequences, then random traffic checked against a register-file model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t state;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.NUM_REGS(4)) bus();

  alu_issue_ctrl #(.NUM_REGS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .state (state)
  );

  // ---------------- downstream ALU + reference ----------------
  // Returns {result, flags}; flags = {opcode, neg, zero, a<b, a==b}.
  function automatic logic [15:0] alu_ref(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    logic [7:0]  r;
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = a << 1;
      OP_SHR:  r = a >> 1;
      OP_INC:  r = a + 8'd1;
      OP_DEC:  r = a - 8'd1;
      OP_MUL:  r = p[7:0];
      OP_DIV:  r = (b == 8'd0) ? 8'hFF : a / b;
      OP_MOD:  r = (b == 8'd0) ? a : a % b;
      OP_CMP:  r = a - b;
      OP_SWAP: r = {a[3:0], a[7:4]};
      default: r = a;
    endcase
    return {r, op, r[7], (r == 8'd0), (a < b), (a == b)};
  endfunction

  always_comb {bus.alu_out, bus.alu_flags} = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // ---------------- scoreboard ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  model [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic load(input logic [1:0] addr, input logic [7:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    #1;
    check("ld_blocks_ready", bus.instr_ready, 1'b0);
    @(negedge clk); #1;
    bus.ld_valid = 1'b0;
    model[addr]  = data;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic wb, input int hold,
                       input logic [7:0] exp_data);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_ref;
    logic [15:0] got;
    int          waitc;
    a       = model[ra];
    b       = model[rb];
    exp_ref = alu_ref(op, a, b);
    bus.res_ready   = (hold == 0);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, ra, rb, wb, 1'($urandom_range(0, 1))};
    #1;
    waitc = 0;
    while (!bus.instr_ready && waitc < 8) begin
      @(negedge clk); #1;
      waitc++;
    end
    check("accept_wait_cycles", waitc, 0);
    exp_q.push_back({exp_data, exp_ref[7:0]});
    if (wb && op != OP_CMP) model[rd] = exp_ref[15:8];
    // cycle N+1
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    check("issue_state", state, ST_ISSUE);
    check("alu_a", bus.alu_a, a);
    check("alu_b", bus.alu_b, b);
    check("alu_opcode", bus.alu_opcode, op);
    check("res_valid_n1", bus.res_valid, 1'b0);
    check("ready_n1", bus.instr_ready, 1'b0);
    // cycle N+2
    @(negedge clk); #1;
    check("capture_state", state, ST_CAPTURE);
    check("res_valid_n2", bus.res_valid, 1'b0);
    // cycle N+3
    @(negedge clk); #1;
    got = exp_q.pop_front();
    check("res_valid_n3", bus.res_valid, 1'b1);
    check("res_data", bus.res_data, got[15:8]);
    check("res_flags", bus.res_flags, got[7:0]);
    check("ready_resp", bus.instr_ready, 1'b0);
    check("alu_a_hold", bus.alu_a, a);
    if (hold > 0) begin
      // Stall the consumer; throw an instruction and loads at the block.
      for (int i = 1; i < hold; i++) begin
        bus.instr_valid = 1'b1;
        bus.instr       = 12'($urandom);
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 2'(i);
        bus.ld_data     = 8'($urandom);
        @(negedge clk); #1;
        check("stall_res_valid", bus.res_valid, 1'b1);
        check("stall_res_data", bus.res_data, got[15:8]);
        check("stall_res_flags", bus.res_flags, got[7:0]);
        check("stall_ready", bus.instr_ready, 1'b0);
        check("stall_state", state, ST_RESP);
      end
      bus.instr_valid = 1'b0;
      bus.ld_valid    = 1'b0;
      bus.res_ready   = 1'b1;
    end
    @(negedge clk); #1;
    check("res_valid_after_hs", bus.res_valid, 1'b0);
    check("idle_after_hs", state, ST_IDLE);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       is_ld;
    logic [3:0] op;
    logic [1:0] rd;    // load address for load records
    logic [1:0] ra;
    logic [1:0] rb;
    logic       wb;
    logic [7:0] data;  // load value, or expected res_data
    int         hold;
  } vec_t;

  function automatic vec_t mk_ld(input logic [1:0] addr, input logic [7:0] data);
    vec_t v;
    v = '{is_ld: 1'b1, op: 4'd0, rd: addr, ra: 2'd0, rb: 2'd0, wb: 1'b0, data: data, hold: 0};
    return v;
  endfunction

  function automatic vec_t mk_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                                 input logic [1:0] rb, input logic wb, input int hold,
                                 input logic [7:0] exp_data);
    vec_t v;
    v = '{is_ld: 1'b0, op: op, rd: rd, ra: ra, rb: rb, wb: wb, data: exp_data, hold: hold};
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs [14];
    logic [3:0]  r_op;
    logic [1:0]  r_rd;
    logic [1:0]  r_ra;
    logic [1:0]  r_rb;
    logic [15:0] r_ref;

    vecs[0]  = mk_ld(2'd0, 8'h12);
    vecs[1]  = mk_ld(2'd1, 8'h34);
    vecs[2]  = mk_op(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b1, 0, 8'h46);
    vecs[3]  = mk_op(OP_SUB, 2'd3, 2'd2, 2'd0, 1'b1, 0, 8'h34);
    vecs[4]  = mk_ld(2'd0, 8'h05);
    vecs[5]  = mk_ld(2'd1, 8'h05);
    vecs[6]  = mk_op(OP_CMP, 2'd0, 2'd0, 2'd1, 1'b1, 0, 8'h00);
    vecs[7]  = mk_op(OP_OR,  2'd0, 2'd0, 2'd0, 1'b1, 0, 8'h05);
    vecs[8]  = mk_op(OP_ADD, 2'd1, 2'd3, 2'd3, 1'b1, 5, 8'h68);
    vecs[9]  = mk_op(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b0, 0, 8'h6D);
    vecs[10] = mk_ld(2'd2, 8'h00);
    vecs[11] = mk_op(OP_DIV, 2'd3, 2'd1, 2'd2, 1'b1, 0, 8'hFF);
    vecs[12] = mk_op(OP_ADD, 2'd1, 2'd1, 2'd1, 1'b1, 0, 8'hD0);
    vecs[13] = mk_op(OP_XOR, 2'd0, 2'd1, 2'd3, 1'b1, 0, 8'h2F);

    // ---- reset ----
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.res_ready   = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    @(negedge clk);
    @(negedge clk); #1;
    check("ready_in_rst", bus.instr_ready, 1'b0);
    check("rst_state", state, ST_IDLE);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_data", bus.res_data, 8'h00);
    check("rst_res_flags", bus.res_flags, 8'h00);
    check("rst_alu_a", bus.alu_a, 8'h00);
    check("rst_alu_b", bus.alu_b, 8'h00);
    check("rst_alu_opcode", bus.alu_opcode, 4'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.instr_ready, 1'b1);

    // ---- directed table ----
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_ld) load(vecs[i].rd, vecs[i].data);
      else issue(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].wb,
                 vecs[i].hold, vecs[i].data);
    end

    // ---- load and instruction offered together: load wins ----
    bus.ld_valid    = 1'b1;
    bus.ld_addr     = 2'd0;
    bus.ld_data     = 8'h21;
    bus.instr_valid = 1'b1;
    bus.instr       = {OP_ADD, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0};
    #1;
    check("simul_ready_low", bus.instr_ready, 1'b0);
    @(negedge clk); #1;
    bus.ld_valid = 1'b0;
    model[0]     = 8'h21;
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b1, 0, 8'hF1);

    // ---- reset during CAPTURE aborts the instruction ----
    load(2'd0, 8'h03);
    bus.instr_valid = 1'b1;
    bus.instr       = {OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0};
    #1;
    check("abort_accept", bus.instr_ready, 1'b1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    check("abort_issue_state", state, ST_ISSUE);
    @(negedge clk); #1;
    check("abort_capture_state", state, ST_CAPTURE);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_res_valid", bus.res_valid, 1'b0);
    check("abort_state", state, ST_IDLE);
    check("abort_ready_in_rst", bus.instr_ready, 1'b0);
    check("abort_alu_a", bus.alu_a, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    #1;
    check("abort_ready_after", bus.instr_ready, 1'b1);
    @(negedge clk); #1;
    check("abort_no_result", bus.res_valid, 1'b0);
    issue(OP_OR, 2'd2, 2'd1, 2'd1, 1'b1, 0, 8'h00);

    // ---- random traffic against the register-file model ----
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        load(2'($urandom_range(0, 3)), 8'($urandom));
      end else begin
        r_op  = 4'($urandom_range(0, 15));
        r_rd  = 2'($urandom_range(0, 3));
        r_ra  = 2'($urandom_range(0, 3));
        r_rb  = 2'($urandom_range(0, 3));
        r_ref = alu_ref(r_op, model[r_ra], model[r_rb]);
        issue(r_op, r_rd, r_ra, r_rb, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), r_ref[15:8]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
